timer_dev: RTL and testbench
============================

# timer_dev

Programmable interval timer that sits on the CPU's data bus as a memory-mapped responder and drives one hardware-interrupt line into CP0's `HWInt` vector. The CPU writes PRESET and CTRL with `sw`, reads COUNT/CTRL/PRESET with `lw`, and takes an interrupt when the count expires. It supports one-shot and periodic auto-reload modes, plus an interrupt mask.

## Interface
Parameters:
- `WIDTH`, 32, width of the data bus and counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `addr`  in  2  word select, from CPU address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we`  in  1  write strobe for one cycle, qualified by the system address decoder.
- `wdata`  in  WIDTH  write data, from the CPU store path (busb).
- `rdata`  out  WIDTH  combinational read of the register selected by `addr`.
- `irq`  out  1  interrupt request to one `HWInt` bit. Level output; equals `ctrl.IM & irq_flag`.

## Operation
- CTRL bit fields:
  - [0] EN, count enable.
  - [2:1] MODE: 00 = one-shot, 01 = periodic; 10 and 11 behave as 00.
  - [3] IM, interrupt mask; 1 = enabled.
  - Bits [31:4] read as 0.
- PRESET: full-width read/write reload value.
- COUNT: read-only. Writes to COUNT and to address 3 are ignored. Address 3 reads 0.
- FSM states and transitions:
  - IDLE: count held. If EN = 1, go to LOAD.
  - LOAD: count <= PRESET; go to CNT.
  - CNT:
    - If EN = 0, go to IDLE with count held.
    - Else if count == 0, go to INT and set irq_flag.
    - Else count <= count − 1.
  - INT, MODE 00: clear EN, go to IDLE. irq_flag stays set.
  - INT, MODE 01: go to LOAD. irq_flag clears on leaving INT, giving a one-cycle pulse.
- Bus write to CTRL or PRESET:
  - Takes effect at that edge and overrides any FSM action in the same cycle.
  - Forces the state to IDLE and clears irq_flag.
  - Does not change count.
  - This is how software acknowledges a one-shot interrupt.
- PRESET = 0: CNT sees 0 on its first cycle, so the expiry takes the minimum latency.
- Counter arithmetic is unsigned WIDTH-bit. The decrement never underflows, because 0 is caught first.

## Timing
- Reset values: state IDLE; CTRL, PRESET, count = 0; irq_flag = 0; `irq` = 0. `rdata` reflects these reset values.
- Reset asserted mid-count clears everything immediately (asynchronous). Counting does not resume after release until software rewrites CTRL.
- Register writes are visible on `rdata` in the cycle after the `we` edge.
- One-shot latency, counting cycle t0 as the CTRL write with EN = 1:
  - IDLE at t1, LOAD at t2.
  - CNT from t3 with count = P, reaching 0 at t3+P.
  - INT at t4+P; `irq` high from t4+P (if IM = 1).
  - Total: P+4 cycles from the write to irq.
- Periodic period: P+3 cycles (INT, LOAD, then P+1 CNT cycles). `irq` is high for exactly 1 cycle per period.
- Clearing EN mid-count: state is IDLE the next cycle and count freezes at its current value. Re-enabling reloads from PRESET; there is no resume.
- Simultaneous CTRL write and count == 0: the write wins. No INT and no irq.
- IM = 0: irq_flag still sets and `irq` stays 0. Setting IM later while the one-shot flag is held raises `irq`, but only if that write does not also clear the flag. In practice any CTRL write clears it, so a masked expiry is lost.

## Structure
- Shared package `timer_pkg` holds:
  - Address offsets: `TMR_CTRL` = 0, `TMR_PRESET` = 1, `TMR_COUNT` = 2.
  - CTRL bit positions: `EN`, `MODE` lsb/msb, `IM`.
  - Mode constants: `MODE_ONESHOT`, `MODE_PERIODIC`.
  - State encoding: IDLE, LOAD, CNT, INT as 2-bit localparams.
- Single module with no sub-module. The register file and the FSM are small enough to live together.
- Instantiated next to `dm` at the top level. The address decoder gates `we`, and the read mux selects `rdata`.

## Test plan
- Reset: assert `rst` = 0 mid-count (PRESET = 10, EN = 1). Expect `irq` = 0, COUNT = 0, CTRL = 0 while low and after release, with no counting.
- One-shot: write PRESET = 5, then CTRL = 0x9 (EN, IM). Expect `irq` rising exactly 9 cycles after the CTRL write, staying high, and CTRL.EN reading 0. A later PRESET write drops `irq` on the next cycle.
- Periodic: PRESET = 3, CTRL = 0xB. Expect one-cycle `irq` pulses every 6 cycles, and COUNT reading the sequence 3, 2, 1, 0 in between.
- Pause: PRESET = 20 with EN. Clear EN when COUNT = 12; expect COUNT to hold at 12 for 10 cycles. Re-enable; expect COUNT to reload to 20.
- Edge cases:
  - PRESET = 0 one-shot: `irq` 4 cycles after the CTRL write.
  - CTRL write in the same cycle the count hits 0: no `irq`.
  - Write to COUNT: COUNT value unchanged.
- Mask: CTRL = 0x1 (IM = 0), PRESET = 2. Expect `irq` to stay 0 through expiry and EN to read 0 afterwards.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the memory-mapped interval timer.
// Holds the register map, CTRL bit layout, mode encodings and FSM state codes.
package timer_pkg;

    // Word offsets on the CPU bus, taken from address bits [3:2]
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    // CTRL bit positions; only the low CTRL_BITS bits are stored
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_BITS     = 4;

    // MODE encodings; the two unused codes fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    // Timer FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // True only for the auto-reload mode; every other MODE value acts as one-shot
    function automatic logic isPeriodic(input logic [CTRL_BITS-1:0] ctrl);
        return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev: programmable interval timer on the CPU data bus.
// Software writes PRESET and CTRL, reads CTRL/PRESET/COUNT, and receives a
// level interrupt (gated by CTRL.IM) when the down-counter expires.
// Supports one-shot and periodic auto-reload operation.
import timer_pkg::*;

module timer_dev #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    logic [1:0]           state_q,   state_d;
    logic [CTRL_BITS-1:0] ctrl_q,    ctrl_d;
    logic [WIDTH-1:0]     preset_q,  preset_d;
    logic [WIDTH-1:0]     count_q,   count_d;
    logic                 irqFlag_q, irqFlag_d;

    logic ctrlWrite;
    logic presetWrite;

    // Decode the bus write strobes; COUNT and the reserved slot are not writable
    assign ctrlWrite   = we && (addr == TMR_CTRL);
    assign presetWrite = we && (addr == TMR_PRESET);

    // Next-state logic: the FSM proposes an update, then any register write
    // overrides it, forcing IDLE, clearing the flag and leaving count alone
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        irqFlag_d = irqFlag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    state_d   = ST_INT;
                    irqFlag_d = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            ST_INT: begin
                if (isPeriodic(ctrl_q)) begin
                    state_d   = ST_LOAD;
                    irqFlag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
        endcase

        if (ctrlWrite || presetWrite) begin
            state_d   = ST_IDLE;
            irqFlag_d = 1'b0;
            count_d   = count_q;
            ctrl_d    = ctrl_q;
        end
        if (ctrlWrite) begin
            ctrl_d = wdata[CTRL_BITS-1:0];
        end
        if (presetWrite) begin
            preset_d = wdata;
        end
    end

    // State and register file, cleared immediately when rst falls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            irqFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            irqFlag_q <= irqFlag_d;
        end
    end

    // Combinational read mux; CTRL upper bits and the reserved word read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            TMR_CTRL:   rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
            TMR_PRESET: rdata = preset_q;
            TMR_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM] & irqFlag_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev.
// The stimulus process drives the bus once per cycle and pushes the expected
// irq/rdata into a queue; a monitor on the falling edge pops and compares.
// Expected values come from a timeline model: each enabling write starts a
// run, and the count/irq/EN at any cycle follow from the cycle offset since
// that write by plain arithmetic.
module tb_timer_dev;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_dev #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [31:0] rdata;
        logic [1:0]  addr;
    } expT;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model state
    longint      cyc;
    longint      runStart;
    bit          running;
    longint      runP;
    logic [3:0]  mCtrl;
    logic [31:0] mPreset;
    logic [31:0] frozenCount;

    // Clear the model the way a reset clears the timer
    function automatic void modelReset();
        running     = 1'b0;
        runStart    = 0;
        runP        = 0;
        mCtrl       = 4'h0;
        mPreset     = 32'h0;
        frozenCount = 32'h0;
    endfunction

    // Whether the current run auto-reloads
    function automatic bit periodicRun();
        return mCtrl[2:1] == 2'b01;
    endfunction

    // Expected COUNT from the cycle offset since the enabling write:
    // two setup cycles, then P..0, then for periodic runs a P+3 cycle repeat
    function automatic logic [31:0] expCount();
        longint j;
        longint m;
        if (!running) return frozenCount;
        j = cyc - runStart;
        if (j <= 1) return frozenCount;
        if (j <= runP + 2) return 32'(runP - (j - 2));
        if (!periodicRun()) return 32'h0;
        m = (j - runP - 3) % (runP + 3);
        if (m <= 1) return 32'h0;
        return 32'(runP - (m - 2));
    endfunction

    // Expected irq: expiry P+3 cycles after the write, held for one-shot,
    // a single cycle per period for periodic
    function automatic logic expIrq();
        longint j;
        if (!running || !mCtrl[3]) return 1'b0;
        j = cyc - runStart;
        if (j < runP + 3) return 1'b0;
        if (!periodicRun()) return 1'b1;
        return ((j - runP - 3) % (runP + 3)) == 0;
    endfunction

    // Expected CTRL: one-shot EN drops the cycle after the expiry cycle
    function automatic logic [3:0] expCtrl();
        logic [3:0] c;
        c = mCtrl;
        if (running && !periodicRun() && (cyc - runStart) >= runP + 4) c[0] = 1'b0;
        return c;
    endfunction

    function automatic logic [31:0] expRead(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, expCtrl()};
            2'd1:    return mPreset;
            2'd2:    return expCount();
            default: return 32'h0;
        endcase
    endfunction

    // A CTRL or PRESET write freezes the count and starts a new run if enabled
    function automatic void modelWrite(input logic [1:0] a, input logic [31:0] d);
        logic [3:0] cur;
        if (a == TMR_CTRL || a == TMR_PRESET) begin
            cur         = expCtrl();
            frozenCount = expCount();
            mCtrl       = cur;
            if (a == TMR_CTRL) mCtrl = d[3:0];
            else               mPreset = d;
            running  = mCtrl[0];
            runP     = longint'(mPreset);
            runStart = cyc + 1;
        end
    endfunction

    // One bus cycle: drive inputs just after a rising edge, queue the expected
    // outputs for this cycle, then advance the model across the next edge
    task automatic applyStimulus(input logic w, input logic [1:0] a,
                                 input logic [31:0] d, input logic r);
        expT e;
        rst   = r;
        we    = w;
        addr  = a;
        wdata = d;
        if (!r) modelReset();
        e.irq   = expIrq();
        e.rdata = expRead(a);
        e.addr  = a;
        expQ.push_back(e);
        @(posedge clk);
        if (w && r) modelWrite(a, d);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, a, 32'h0, 1'b1);
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT against the queued expectation every falling edge
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("irq", {31'h0, irq}, {31'h0, e.irq});
                checkOutput($sformatf("rdata[addr=%0d]", e.addr), rdata, e.rdata);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized bus traffic
    initial begin
        int r;
        rst   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'h0;
        cyc   = 0;
        modelReset();
        @(posedge clk);
        #1;

        // Reset values, then release
        applyStimulus(1'b0, TMR_CTRL,   32'h0, 1'b0);
        applyStimulus(1'b0, TMR_PRESET, 32'h0, 1'b0);
        applyStimulus(1'b0, TMR_COUNT,  32'h0, 1'b0);
        idle(2, TMR_COUNT);

        // Reset asserted mid-count, no counting after release
        busWrite(TMR_PRESET, 32'd10);
        busWrite(TMR_CTRL, 32'h1);
        idle(6, TMR_COUNT);
        applyStimulus(1'b0, TMR_COUNT, 32'h0, 1'b0);
        applyStimulus(1'b0, TMR_CTRL,  32'h0, 1'b0);
        applyStimulus(1'b0, TMR_COUNT, 32'h0, 1'b0);
        idle(5, TMR_COUNT);
        idle(2, TMR_CTRL);

        // One-shot with IM, then acknowledge with a PRESET write
        busWrite(TMR_PRESET, 32'd5);
        busWrite(TMR_CTRL, 32'h9);
        idle(14, TMR_CTRL);
        busWrite(TMR_PRESET, 32'd7);
        idle(3, TMR_COUNT);

        // Periodic pulses
        busWrite(TMR_PRESET, 32'd3);
        busWrite(TMR_CTRL, 32'hB);
        idle(20, TMR_COUNT);

        // Pause and re-enable
        busWrite(TMR_PRESET, 32'd20);
        busWrite(TMR_CTRL, 32'h9);
        idle(10, TMR_COUNT);
        busWrite(TMR_CTRL, 32'h8);
        idle(10, TMR_COUNT);
        busWrite(TMR_CTRL, 32'h9);
        idle(6, TMR_COUNT);

        // PRESET = 0 one-shot: minimum latency
        busWrite(TMR_PRESET, 32'd0);
        busWrite(TMR_CTRL, 32'h9);
        idle(6, TMR_CTRL);

        // CTRL write landing on the cycle the count reaches zero
        busWrite(TMR_PRESET, 32'd4);
        busWrite(TMR_CTRL, 32'hB);
        idle(6, TMR_COUNT);
        busWrite(TMR_CTRL, 32'h8);
        idle(4, TMR_COUNT);

        // Writes to COUNT and the reserved word are ignored
        busWrite(TMR_PRESET, 32'd6);
        busWrite(TMR_CTRL, 32'h9);
        idle(4, TMR_COUNT);
        busWrite(TMR_COUNT, 32'h55);
        busWrite(2'd3, 32'hFFFF_FFFF);
        idle(3, TMR_COUNT);
        idle(2, 2'd3);

        // Masked expiry
        busWrite(TMR_CTRL, 32'h0);
        busWrite(TMR_PRESET, 32'd2);
        busWrite(TMR_CTRL, 32'h1);
        idle(10, TMR_CTRL);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                applyStimulus(1'b0, 2'($urandom_range(0, 3)), 32'h0, 1'b0);
                applyStimulus(1'b0, TMR_COUNT, 32'h0, 1'b0);
            end else if (r < 12) begin
                logic [31:0] c;
                c = $urandom & 32'hF;
                if ($urandom_range(0, 3) != 0) c[0] = 1'b1;
                busWrite(TMR_CTRL, c);
            end else if (r < 20) begin
                busWrite(TMR_PRESET, 32'($urandom_range(0, 12)));
            end else if (r < 23) begin
                busWrite(TMR_COUNT, $urandom);
            end else if (r < 25) begin
                busWrite(2'd3, $urandom);
            end else begin
                idle(1, 2'($urandom_range(0, 3)));
            end
        end

        busWrite(TMR_CTRL, 32'h0);
        idle(2, TMR_CTRL);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
